// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: fetch request, instruction memory and IF/ID handshake bundle
// master: fetch unit side (drives imem request, fetch ready, IF/ID outputs, error flag)
// slave: surrounding PC stage, memory and decode (drive requests, memory responses, ready, flush)
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              fetch_req_valid;
  logic [ADDR_W-1:0] fetch_req_addr;
  logic              fetch_req_ready;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [ADDR_W-1:0] if_pc;
  logic              flush;
  logic              fetch_err;
  modport master (
    input  fetch_req_valid, fetch_req_addr, imem_gnt, imem_rvalid, imem_rdata, if_ready, flush,
    output fetch_req_ready, imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_err
  );
  modport slave (
    output fetch_req_valid, fetch_req_addr, imem_gnt, imem_rvalid, imem_rdata, if_ready, flush,
    input  fetch_req_ready, imem_req, imem_addr, if_valid, if_instr, if_pc, fetch_err
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: issues PC fetches to imem, pairs returned words with their PC, delivers in order
// clk: rising-edge clock; reset: asynchronous active-low reset
// bus (master): fetch_req_* from PC stage, imem_* to memory, if_* to IF/ID, flush, fetch_err
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input logic                clk,
  input logic                reset,
  instr_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] ob_instr [DEPTH];
  logic [ADDR_W-1:0] ob_pc [DEPTH];
  logic [PW-1:0] pc_wp, pc_rp, ob_wp, ob_rp, head;
  logic [CW-1:0] live, disc, ob_cnt;
  logic [CW:0] total;
  logic credit_ok, push, any, rsp, deliver, pop, err;
  always_comb begin
    total     = {1'b0, live} + {1'b0, disc} + {1'b0, ob_cnt};
    credit_ok = total < (CW+1)'(DEPTH);
    bus.imem_req  = reset & bus.fetch_req_valid & credit_ok & ~bus.flush;
    bus.imem_addr = {bus.fetch_req_addr[ADDR_W-1:2], 2'b00};
    push    = bus.imem_req & bus.imem_gnt;
    any     = (live != '0) || (disc != '0);
    rsp     = bus.imem_rvalid & any;
    deliver = rsp & ~bus.flush & (disc == '0);
    pop     = (ob_cnt != '0) & bus.if_ready;
    // when empty, the slot behind the read pointer is the last word shown
    head    = (ob_cnt != '0) ? ob_rp : ob_rp - PW'(1);
  end
  assign bus.fetch_req_ready = push;
  assign bus.if_valid  = ob_cnt != '0;
  assign bus.if_instr  = ob_instr[head];
  assign bus.if_pc     = ob_pc[head];
  assign bus.fetch_err = err;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_wp  <= '0;
      pc_rp  <= '0;
      ob_wp  <= '0;
      ob_rp  <= '0;
      live   <= '0;
      disc   <= '0;
      ob_cnt <= '0;
      err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        ob_instr[i] <= '0;
        ob_pc[i]    <= '0;
      end
    end else begin
      if (push) begin
        pc_mem[pc_wp] <= bus.fetch_req_addr;
        pc_wp         <= pc_wp + PW'(1);
      end
      if (rsp) pc_rp <= pc_rp + PW'(1);
      if (bus.imem_rvalid && !any) err <= 1'b1;
      if (bus.flush) begin
        // a response in the flush cycle retires the oldest entry without output
        live   <= '0;
        disc   <= disc + live - CW'(rsp);
        ob_cnt <= '0;
        // retire the shown head so if_instr/if_pc keep their value while empty
        if (ob_cnt != '0) begin
          ob_rp <= ob_rp + PW'(1);
          ob_wp <= ob_rp + PW'(1);
        end
      end else begin
        live   <= live + CW'(push) - CW'(deliver);
        disc   <= disc - CW'(rsp & (disc != '0));
        ob_cnt <= ob_cnt + CW'(deliver) - CW'(pop);
        if (pop) ob_rp <= ob_rp + PW'(1);
        if (deliver) begin
          ob_instr[ob_wp] <= bus.imem_rdata;
          ob_pc[ob_wp]    <= pc_mem[pc_rp];
          ob_wp           <= ob_wp + PW'(1);
        end
      end
    end
  end
endmodule
